alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the team's 4-bit combinational ALU. It keeps the same 8-opcode set but takes a WIDTH-bit operand width. It uses a valid/ready handshake on both input and output. MUL and DIV run iteratively in an internal state machine instead of as combinational arrays. The block sits between an operand issue stage and a result writeback stage. It holds one operation in flight at a time.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); result width is 2*WIDTH.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  reset; synchronous, active-low.
in_valid  input  1  A, B and opcode are valid.
in_ready  output  1  block can accept an operation.
A  input  WIDTH  operand A (unsigned).
B  input  WIDTH  operand B (unsigned).
opcode  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 NAND, 101 NOT, 110 CMP, 111 AVG.
out_valid  output  1  result and carry_out are valid.
out_ready  input  1  consumer accepts the result.
result  output  2*WIDTH  operation result.
carry_out  output  1  carry, borrow or divide-by-zero flag.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state to IDLE; in_ready=1, out_valid=0, result=0, carry_out=0; counter and datapath registers cleared.
  - Reset in BUSY or DONE abandons the operation; no out_valid follows.
- Handshakes:
  - Input accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = (state==IDLE); no combinational path from out_ready to in_ready.
- FSM states IDLE, BUSY, DONE:
  - IDLE, accept with a single-cycle op (ADD, SUB, NAND, NOT, CMP, AVG): compute into output registers, go to DONE. out_valid is high the cycle after accept.
  - IDLE, accept with MUL, or DIV with B!=0: latch operands, counter=WIDTH, go to BUSY.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle. When the counter reaches 0, load the output registers and go to DONE. out_valid rises exactly WIDTH+1 cycles after accept.
  - DONE: result and carry_out held stable while out_valid=1 && out_ready=0. On transfer, go to IDLE; in_ready=1 the next cycle. Minimum throughput is one op per 2 cycles.
  - in_valid while not in IDLE is ignored; input values are don't-care.
- Arithmetic (all unsigned; upper bits zero-extended unless stated):
  - ADD: result low WIDTH = (A+B) mod 2^WIDTH; carry_out = bit WIDTH of the sum.
  - SUB: result low WIDTH = (A-B) mod 2^WIDTH; carry_out = borrow (1 iff A<B).
  - MUL: result = full 2*WIDTH-bit product; carry_out=0.
  - DIV, B!=0: result = {remainder, quotient} (remainder in the upper WIDTH bits); carry_out=0.
  - DIV, B==0: single-cycle path (out_valid the cycle after accept); result = {A, all-ones}; carry_out=1.
  - NAND: ~(A&B). NOT: ~A (B ignored). carry_out=0 for both.
  - CMP: result=1 iff A>B, else 0; carry_out=0.
  - AVG: (A+B)>>1 computed with a WIDTH+1-bit sum, so no overflow loss; carry_out=0.
- Operands are latched at accept; input changes after accept have no effect.
- result and carry_out keep their last value after a transfer until the next completion.

Test Plan (WIDTH=8):
- ADD A=200, B=100, out_ready=1 -> out_valid the cycle after accept; result=0x002C, carry_out=1; SUB A=5, B=9 -> result=0x00FC, carry_out=1.
- MUL A=255, B=255 -> in_ready low for 9 cycles; out_valid exactly 9 cycles after accept; result=0xFE01, carry_out=0.
- DIV A=200, B=7 -> result=0x041C after 9 cycles; DIV A=0x55, B=0 -> result=0x55FF, carry_out=1, out_valid the cycle after accept.
- AVG A=255, B=255 -> result=0x00FF; CMP A=3, B=3 -> 0x0000; CMP A=4, B=3 -> 0x0001; NOT A=0x0F -> 0x00F0.
- Backpressure: ADD completes, out_ready held low 3 cycles -> result, carry_out and out_valid stable; in_ready=0; a new in_valid pulse is ignored. Raise out_ready -> one transfer, then in_ready=1.
- rst_n low for 1 cycle at cycle 4 of a MUL -> next cycle in_ready=1, out_valid=0, result=0; no stale completion; a following ADD 1+1 returns 0x0002.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish on accept; MUL and DIV iterate one bit per cycle.
`timescale 1ns/1ps
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry_out
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;
    localparam logic [2:0] OP_AVG  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_b;
    logic                 r_is_div;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_carry;

    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_multi;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_sc_res;
    logic                 w_sc_carry;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [WIDTH-1:0]     w_hi_nxt;
    logic [WIDTH-1:0]     w_lo_nxt;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_carry;

    assign w_accept = in_valid && in_ready;
    assign w_xfer   = out_valid && out_ready;
    assign w_multi  = (opcode == OP_MUL) || ((opcode == OP_DIV) && (B != '0));
    assign w_last   = (r_cnt == CW'(1));

    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        w_sc_res   = '0;
        w_sc_carry = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_sc_res[WIDTH-1:0] = w_sum[WIDTH-1:0];
                w_sc_carry          = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_sc_res[WIDTH-1:0] = w_diff[WIDTH-1:0];
                w_sc_carry          = w_diff[WIDTH];
            end
            OP_DIV: begin
                // only reached with B==0: flag divide-by-zero
                w_sc_res   = {A, {WIDTH{1'b1}}};
                w_sc_carry = 1'b1;
            end
            OP_NAND: w_sc_res[WIDTH-1:0] = ~(A & B);
            OP_NOT:  w_sc_res[WIDTH-1:0] = ~A;
            OP_CMP:  w_sc_res[0]         = (A > B);
            OP_AVG:  w_sc_res[WIDTH-1:0] = w_sum[WIDTH:1];
            default: w_sc_res            = '0;
        endcase
    end

    // Shift-add multiply: {r_hi,r_lo} holds partial product and remaining multiplier.
    // Restoring divide: r_hi is the remainder, r_lo shifts dividend out and quotient in.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_is_div) begin
            if (!w_div_diff[WIDTH]) begin
                w_hi_nxt = w_div_diff[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_div_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_hi_nxt = w_mul_sum[WIDTH:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_multi ? S_BUSY : S_DONE;
            S_BUSY:  if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  if (w_xfer)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else if (w_accept) begin
            if (w_multi) begin
                r_hi     <= '0;
                r_lo     <= A;
                r_b      <= B;
                r_is_div <= (opcode == OP_DIV);
                r_cnt    <= CW'(WIDTH);
            end else begin
                r_result <= w_sc_res;
                r_carry  <= w_sc_carry;
            end
        end else if (r_state == S_BUSY) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_result <= {w_hi_nxt, w_lo_nxt};
                r_carry  <= 1'b0;
            end
        end
    end
endmodule
